tridiag_det_stream: RTL
=======================

# tridiag_det_stream

Streaming, parametrised tridiagonal determinant engine. It is the successor to the fixed-size flat-bus determinant block. Matrix rows arrive one per cycle over a valid/ready stream, and matrix length is set at run time by a `last` marker up to `MAX_N`. Results leave on a valid/ready output stream and carry overflow and truncation flags. An optional mode emits every leading principal minor, not just the final determinant.

## Interface
Parameters:
- `MAX_N`, 32: maximum matrix order accepted; must be ≥ 1.
- `WIDTH`, 16: signed element width of a, b, c.
- `ACC_WIDTH`, 48: signed accumulator/result width; must be ≥ 2*WIDTH.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  row k present.
- `in_ready`  out  1  row accepted when `in_valid && in_ready`.
- `in_a`  in  WIDTH  signed sub-diagonal a[k-1]; ignored for k=0.
- `in_b`  in  WIDTH  signed diagonal b[k].
- `in_c`  in  WIDTH  signed super-diagonal c[k-1]; ignored for k=0.
- `in_last`  in  1  row k is the final row of this matrix.
- `in_mode`  in  1  0 = FULL (emit final det only), 1 = MINORS (emit D_k per row); sampled on row 0 only.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `out_det`  out  ACC_WIDTH  signed determinant / minor.
- `out_len`  out  $clog2(MAX_N+1)  order of the reported minor (k+1).
- `out_last`  out  1  this output closes the matrix.
- `out_ovf`  out  1  sticky: some D_j, j ≤ k, of this matrix exceeded ACC_WIDTH.
- `out_trunc`  out  1  matrix force-terminated at MAX_N rows without `in_last`.

## Operation
- Recurrence: D_{-1}=1, D_{-2}=0, D_k = b_k·D_{k-1} − (a_{k-1}·c_{k-1})·D_{k-2}, with the a·c term forced to 0 for k=0.
- State: `D1` (D_{k-1}), `D0` (D_{k-2}), row counter `k`, latched mode, sticky ovf.
- FSM states:
  - IDLE: waiting for row 0. On acceptance, load mode, set D1=b0, D0=1, clear ovf, set k=1, then go to RUN, or stay in IDLE if `in_last`.
  - RUN: each accepted row computes D_k, shifts D0←D1, D1←D_k, and increments k. On `in_last`, or on the MAX_N-th row, return to IDLE.
- Arithmetic:
  - a·c is exact at 2*WIDTH.
  - Both products are formed at 2*ACC_WIDTH and subtracted at 2*ACC_WIDTH+1.
  - The result is truncated to ACC_WIDTH (two's-complement wrap).
  - ovf sets when the full-precision result is not representable in ACC_WIDTH. It stays set until the next row 0.
  - Later rows keep using the wrapped value.
- Output generation:
  - MINORS mode: every accepted row writes the output register with D_k, len=k+1, last=`in_last`||forced.
  - FULL mode: only the final row writes the output register.
- Forced termination: the MAX_N-th row without `in_last` produces an output with `out_last`=1 and `out_trunc`=1. The next accepted row is treated as row 0 of a new matrix.
- Flow control: `in_ready = !out_valid || out_ready`, in both modes. This single rule keeps the output register lossless.
- A matrix of order 1 yields det=b0, len=1, last=1.

## Timing
- Reset values: all outputs are 0 except `in_ready`=1, `out_valid`=0. FSM is IDLE, k=0, D0=1, D1=0.
- Latency: the result for a row accepted at edge t appears, with `out_valid`=1, after edge t (one cycle).
- Throughput: one row per cycle while `out_ready`=1.
- `out_*` must hold stable while `out_valid && !out_ready`.
- Simultaneous output pop and new result on the same edge: the register is overwritten and `out_valid` stays 1.
- Pop with no new result: `out_valid` → 0.
- `in_*` other than valid are don't-care when `in_valid`=0.
- `in_mode` changes mid-matrix are ignored.
- `rst_n` low mid-matrix or mid-output:
  - The partial matrix is discarded and any pending output is dropped.
  - `in_ready`=1 is re-asserted asynchronously.
  - The first row after release is row 0.

## Structure
- Package `tridiag_pkg`:
  - `mode_e` (FULL, MINORS);
  - `state_e` (IDLE, RUN);
  - a `LEN_W(MAX_N)` width function.
- Sub-module `tridiag_step`: combinational. Takes D1, D0, a, b, c, and a first-row flag. Produces D_k (ACC_WIDTH) and an ovf bit. It is the only arithmetic in the block and is unit-testable alone.
- Top: FSM, counter, D registers, output register, flow control.

## Test plan
- FULL, WIDTH=16, ACC=48, rows b=(2,2,2), a=c=(1,1), last on row 2 → one output: det=4, len=3, last=1, ovf=0, trunc=0.
- MINORS, same matrix → three outputs on consecutive cycles: (2,len1), (3,len2), (4,len3,last).
- ACC_WIDTH=32, MINORS, b=(32767,32767,32767), a=c=0 → outputs:
  - row 0: 32767, ovf=0;
  - row 1: 1073676289, ovf=0;
  - row 2: ovf=1, with det = low 32 bits of 32767³.
- Order-1 matrix b=−5 with last, followed back-to-back by the 3×3 matrix → outputs: det −5 (len1), then det 4 (len3). No inter-matrix bubble.
- MINORS with `out_ready` held low for 3 cycles mid-matrix → `in_ready` drops after the first output, `out_det` stays stable, and no minor is lost or duplicated.
- MAX_N=4, five rows with no `in_last` → output with len=4, last=1, trunc=1. Row 5 is processed as a new order-1 matrix. Repeat with `rst_n` pulsed after row 2 → no output, and the next matrix is correct.

Source files
------------

// File: rtl/tridiag_det_stream_pkg.sv
// Shared types and sizing helpers for the streaming tridiagonal determinant engine.
package tridiag_pkg;

  typedef enum logic {
    FULL   = 1'b0,
    MINORS = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bits needed to hold a minor order in 1..max_n.
  function automatic int LEN_W(input int max_n);
    return $clog2(max_n + 1);
  endfunction

endpackage

// File: rtl/tridiag_det_stream_if.sv
// Row input stream and result output stream of tridiag_det_stream.
interface tridiag_det_stream_if #(
  parameter int MAX_N     = 32,
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 48
);
  localparam int LW = tridiag_pkg::LEN_W(MAX_N);

  logic                        in_valid;
  logic                        in_ready;
  logic signed [WIDTH-1:0]     in_a;
  logic signed [WIDTH-1:0]     in_b;
  logic signed [WIDTH-1:0]     in_c;
  logic                        in_last;
  logic                        in_mode;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] out_det;
  logic [LW-1:0]               out_len;
  logic                        out_last;
  logic                        out_ovf;
  logic                        out_trunc;

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_last, in_mode, out_ready,
    output in_ready, out_valid, out_det, out_len, out_last, out_ovf, out_trunc
  );

  modport master (
    output in_valid, in_a, in_b, in_c, in_last, in_mode, out_ready,
    input  in_ready, out_valid, out_det, out_len, out_last, out_ovf, out_trunc
  );

endinterface

// File: rtl/tridiag_det_stream_step.sv
// One step of the continuant recurrence D_k = b*D1 - (a*c)*D0, wrapped to ACC_WIDTH.
module tridiag_step #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 48
) (
  input  logic signed [ACC_WIDTH-1:0] d1_i,
  input  logic signed [ACC_WIDTH-1:0] d0_i,
  input  logic signed [WIDTH-1:0]     a_i,
  input  logic signed [WIDTH-1:0]     b_i,
  input  logic signed [WIDTH-1:0]     c_i,
  input  logic                        first_i,
  output logic signed [ACC_WIDTH-1:0] dk_o,
  output logic                        ovf_o
);
  localparam int PW = 2 * ACC_WIDTH;

  logic [2*WIDTH-1:0] ac;
  logic [PW-1:0]      p_bd;
  logic [PW-1:0]      p_acd;
  logic [PW:0]        diff;

  // Operands are sign-extended to the product width; the low bits of an
  // unsigned product then equal the exact signed product.
  always_comb begin
    ac    = first_i ? '0
                    : {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{c_i[WIDTH-1]}}, c_i};
    p_bd  = {{ACC_WIDTH{d1_i[ACC_WIDTH-1]}}, d1_i} * {{(PW-WIDTH){b_i[WIDTH-1]}}, b_i};
    p_acd = {{(PW-2*WIDTH){ac[2*WIDTH-1]}}, ac} * {{ACC_WIDTH{d0_i[ACC_WIDTH-1]}}, d0_i};
    diff  = {p_bd[PW-1], p_bd} - {p_acd[PW-1], p_acd};
    dk_o  = diff[ACC_WIDTH-1:0];
    // Representable only if every bit above the result sign matches it.
    ovf_o = !((&diff[PW:ACC_WIDTH-1]) || !(|diff[PW:ACC_WIDTH-1]));
  end

endmodule

// File: rtl/tridiag_det_stream.sv
// Streaming tridiagonal determinant engine: one row per cycle in, final det or every minor out.
module tridiag_det_stream
  import tridiag_pkg::*;
#(
  parameter int MAX_N     = 32,
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 48
) (
  input logic                  clk,
  input logic                  rst_n,
  tridiag_det_stream_if.slave  bus
);
  localparam int              LW      = LEN_W(MAX_N);
  localparam logic [LW-1:0]   MAX_LEN = LW'(MAX_N);
  localparam logic [ACC_WIDTH-1:0] ONE = ACC_WIDTH'(1);

  state_e                      state_q, state_d;
  mode_e                       mode_q, mode_d, mode_cur;
  logic [LW-1:0]               k_q, k_d, row_len;
  logic signed [ACC_WIDTH-1:0] d1_q, d1_d, d0_q, d0_d;
  logic signed [ACC_WIDTH-1:0] d1_eff, d0_eff, step_dk;
  logic                        ovf_q, ovf_d, step_ovf, ovf_row;
  logic                        accept, first, done, forced, emit;

  logic                        out_valid_q, out_valid_d;
  logic signed [ACC_WIDTH-1:0] out_det_q, out_det_d;
  logic [LW-1:0]               out_len_q, out_len_d;
  logic                        out_last_q, out_last_d;
  logic                        out_ovf_q, out_ovf_d;
  logic                        out_trunc_q, out_trunc_d;

  // A row can enter whenever the output register is free or being drained.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign first        = (state_q == IDLE);
  assign d1_eff       = first ? ONE : d1_q;
  assign d0_eff       = first ? '0  : d0_q;

  tridiag_step #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_step (
    .d1_i    (d1_eff),
    .d0_i    (d0_eff),
    .a_i     (bus.in_a),
    .b_i     (bus.in_b),
    .c_i     (bus.in_c),
    .first_i (first),
    .dk_o    (step_dk),
    .ovf_o   (step_ovf)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d     = state_q;
    mode_d      = mode_q;
    k_d         = k_q;
    d1_d        = d1_q;
    d0_d        = d0_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_det_d   = out_det_q;
    out_len_d   = out_len_q;
    out_last_d  = out_last_q;
    out_ovf_d   = out_ovf_q;
    out_trunc_d = out_trunc_q;

    row_len  = (first ? '0 : k_q) + LW'(1);
    mode_cur = first ? mode_e'(bus.in_mode) : mode_q;
    forced   = !bus.in_last && (row_len == MAX_LEN);
    done     = bus.in_last || forced;
    ovf_row  = (!first && ovf_q) || step_ovf;
    emit     = accept && (mode_cur == MINORS || done);

    if (accept) begin
      mode_d  = mode_cur;
      d0_d    = d1_eff;
      d1_d    = step_dk;
      ovf_d   = ovf_row;
      k_d     = done ? '0 : row_len;
      state_d = done ? IDLE : RUN;
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_det_d   = step_dk;
      out_len_d   = row_len;
      out_last_d  = done;
      out_ovf_d   = ovf_row;
      out_trunc_d = forced;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= FULL;
      k_q         <= '0;
      d1_q        <= '0;
      d0_q        <= ONE;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_det_q   <= '0;
      out_len_q   <= '0;
      out_last_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      k_q         <= k_d;
      d1_q        <= d1_d;
      d0_q        <= d0_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_det_q   <= out_det_d;
      out_len_q   <= out_len_d;
      out_last_q  <= out_last_d;
      out_ovf_q   <= out_ovf_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_det   = out_det_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_trunc = out_trunc_q;

endmodule
